// File: rtl/day_of_week_ctrl.sv
// Day-of-week register with RUN/SET modes, button edge conditioning and SET-mode blink.
// Drives day_idx (always 0..6) to the downstream day-name 7-segment decoders.

module dow_btn_cond (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);
   logic s1, s2, prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign pulse = s2 & ~prev;
endmodule

module day_of_week_ctrl #(
   parameter int BLINK_DIV = 25000000,
   parameter int DAY_RESET = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       day_tick,
   output logic [2:0] day_idx,
   output logic       set_mode,
   output logic       blink,
   output logic       week_wrap
);
   localparam int NUM_BTN = 3;
   localparam int CW      = $clog2(BLINK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

   typedef enum logic {ST_RUN, ST_SET} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [NUM_BTN-1:0]   btn_raw;
   logic [NUM_BTN-1:0]   btn_edge;
   logic                 mode_e, up_e, down_e;

   assign btn_raw = {btn_down, btn_up, btn_mode};

   genvar g;
   generate
      for (g = 0; g < NUM_BTN; g++) begin : g_btn
         dow_btn_cond u_cond (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw[g]),
            .pulse (btn_edge[g])
         );
      end
   endgenerate

   assign mode_e = btn_edge[0];
   assign up_e   = btn_edge[1];
   assign down_e = btn_edge[2];

   function automatic logic [2:0] inc7(input logic [2:0] d);
      return (d >= 3'd6) ? 3'd0 : d + 3'd1;
   endfunction

   function automatic logic [2:0] dec7(input logic [2:0] d);
      return (d == 3'd0 || d > 3'd6) ? 3'd6 : d - 3'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         day_idx   <= 3'(DAY_RESET);
         set_mode  <= 1'b0;
         blink     <= 1'b1;
         week_wrap <= 1'b0;
         cnt       <= '0;
      end else begin
         week_wrap <= 1'b0;
         case (state)
            ST_RUN: begin
               // Midnight advance and mode entry may land on the same edge.
               if (day_tick) begin
                  day_idx <= inc7(day_idx);
                  if (day_idx == 3'd6) week_wrap <= 1'b1;
               end
               blink <= 1'b1;
               cnt   <= '0;
               if (mode_e) begin
                  state    <= ST_SET;
                  set_mode <= 1'b1;
               end
            end
            ST_SET: begin
               if (mode_e) begin
                  state    <= ST_RUN;
                  set_mode <= 1'b0;
                  blink    <= 1'b1;
                  cnt      <= '0;
               end else if (up_e || down_e) begin
                  if (up_e && !down_e)      day_idx <= inc7(day_idx);
                  else if (down_e && !up_e) day_idx <= dec7(day_idx);
                  blink <= 1'b1;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  cnt   <= '0;
                  blink <= ~blink;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= ST_RUN;
               set_mode <= 1'b0;
               blink    <= 1'b1;
               cnt      <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_day_of_week_ctrl.sv
// Directed self-checking bench for day_of_week_ctrl with BLINK_DIV=4, DAY_RESET=0.

module tb_day_of_week_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode, btn_up, btn_down, day_tick;
   logic [2:0] day_idx;
   logic       set_mode, blink, week_wrap;

   int n_assert = 0;
   int n_fail   = 0;

   day_of_week_ctrl #(.BLINK_DIV(4), .DAY_RESET(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .day_tick  (day_tick),
      .day_idx   (day_idx),
      .set_mode  (set_mode),
      .blink     (blink),
      .week_wrap (week_wrap)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; day_tick = 1'b0;
      step(2);
      chk("rst_day", 32'(day_idx), 0);
      chk("rst_set", 32'(set_mode), 0);
      chk("rst_blink", 32'(blink), 1);
      chk("rst_wrap", 32'(week_wrap), 0);
      rst = 1'b0;
      step(2);

      // RUN: seven midnight ticks, five cycles apart
      for (int i = 1; i <= 7; i++) begin
         day_tick = 1'b1;
         step();
         day_tick = 1'b0;
         chk($sformatf("run_day%0d", i), 32'(day_idx), i % 7);
         chk($sformatf("run_wrap%0d", i), 32'(week_wrap), (i == 7) ? 1 : 0);
         chk($sformatf("run_set%0d", i), 32'(set_mode), 0);
         chk($sformatf("run_blink%0d", i), 32'(blink), 1);
         for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("run_wrap_gap%0d_%0d", i, j), 32'(week_wrap), 0);
         end
      end

      // Enter SET: action lands on the third edge after the rise
      btn_mode = 1'b1;
      step(2);
      chk("mode_early", 32'(set_mode), 0);
      step();
      chk("mode_set", 32'(set_mode), 1);
      chk("mode_blink", 32'(blink), 1);
      btn_mode = 1'b0;
      step(3);

      btn_down = 1'b1;
      step(2);
      chk("down_early", 32'(day_idx), 0);
      step();
      chk("down_0to6", 32'(day_idx), 6);
      btn_down = 1'b0;
      step(3);
      btn_up = 1'b1;
      step(3);
      chk("up_6to0", 32'(day_idx), 0);
      btn_up = 1'b0;
      step(3);
      btn_up = 1'b1;
      step(3);
      chk("up_0to1", 32'(day_idx), 1);
      btn_up = 1'b0;
      step(3);
      chk("set_wrap0", 32'(week_wrap), 0);
      chk("set_mode1", 32'(set_mode), 1);

      // Blink: restart from an up press, then 1111 0000 1111
      btn_up = 1'b1;
      step(3);
      chk("blink_day", 32'(day_idx), 2);
      chk("blink_0", 32'(blink), 1);
      btn_up = 1'b0;
      for (int i = 1; i < 12; i++) begin
         step();
         chk($sformatf("blink_%0d", i), 32'(blink), ((i / 4) % 2 == 0) ? 1 : 0);
      end
      step();
      chk("blink_low_a", 32'(blink), 0);
      btn_up = 1'b1;
      step();
      chk("blink_low_b", 32'(blink), 0);
      step();
      chk("blink_low_c", 32'(blink), 0);
      step();
      chk("blink_forced", 32'(blink), 1);
      chk("blink_up_day", 32'(day_idx), 3);
      btn_up = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("blink_restart_hi%0d", i), 32'(blink), 1);
      end
      step();
      chk("blink_restart_lo", 32'(blink), 0);

      // day_tick ignored in SET
      for (int i = 0; i < 2; i++) begin
         day_tick = 1'b1;
         step();
         day_tick = 1'b0;
         step();
         chk($sformatf("set_tick%0d", i), 32'(day_idx), 3);
         chk($sformatf("set_tick_wrap%0d", i), 32'(week_wrap), 0);
      end

      // up and down together: no change
      btn_up = 1'b1; btn_down = 1'b1;
      step(4);
      chk("updown_same", 32'(day_idx), 3);
      btn_up = 1'b0; btn_down = 1'b0;
      step(3);

      // long hold: one increment only
      btn_up = 1'b1;
      step(100);
      btn_up = 1'b0;
      step(3);
      chk("hold_once", 32'(day_idx), 4);

      // mode and up together: only the mode transition
      btn_mode = 1'b1; btn_up = 1'b1;
      step(3);
      chk("modeup_run", 32'(set_mode), 0);
      chk("modeup_day", 32'(day_idx), 4);
      chk("modeup_blink", 32'(blink), 1);
      btn_mode = 1'b0; btn_up = 1'b0;
      step(3);

      // RUN ignores up presses
      btn_up = 1'b1;
      step(4);
      chk("run_up_ignored", 32'(day_idx), 4);
      btn_up = 1'b0;
      step(3);

      // reset while in SET
      btn_mode = 1'b1;
      step(3);
      chk("reenter_set", 32'(set_mode), 1);
      btn_mode = 1'b0;
      step(3);
      chk("pre_rst_day", 32'(day_idx), 4);
      rst = 1'b1;
      step();
      chk("midrst_day", 32'(day_idx), 0);
      chk("midrst_set", 32'(set_mode), 0);
      chk("midrst_blink", 32'(blink), 1);
      chk("midrst_wrap", 32'(week_wrap), 0);
      rst = 1'b0;
      step(4);
      chk("post_rst_set", 32'(set_mode), 0);
      chk("post_rst_day", 32'(day_idx), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/day_of_week_ctrl.md
Name: day_of_week_ctrl

Overview:
- Holds the current day of week as a 3-bit index: 0=Mon, 1=Tue, 2=Wed, 3=Thu, 4=Fri, 5=Sat, 6=Sun.
- Drives the day_idx bus consumed by the per-character day-name 7-segment decoders, which are directly downstream.
- RUN mode: advances on the midnight tick from the time-of-day chain.
- SET mode: the user steps the day with push-buttons while the day display blinks.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period in SET mode (must be >= 2).
- DAY_RESET, 0, day index loaded at reset (must be 0..6).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- btn_mode  input  1  raw mode button, asynchronous, level-high when pressed.
- btn_up  input  1  raw increment button, asynchronous, level-high.
- btn_down  input  1  raw decrement button, asynchronous, level-high.
- day_tick  input  1  one-cycle pulse at midnight, synchronous to clk.
- day_idx  output  3  current day index, always 0..6, registered.
- set_mode  output  1  1 while in SET state, registered.
- blink  output  1  display enable for the day digits, registered.
- week_wrap  output  1  one-cycle pulse when RUN advance goes 6->0, registered.

Behaviour:
- One clock domain. Reset is synchronous and active-high: all registers update only on rising clk, and rst is sampled on that edge.
- Reset values:
  - day_idx=DAY_RESET, set_mode=0, blink=1, week_wrap=0.
  - State RUN, blink counter=0.
  - All synchronizer and edge-detect flops=0.
- Reset has priority over every other input.
- Reset mid-SET returns to RUN and discards any pending button edges.
- Button conditioning, per button:
  - 2-flop synchronizer (s1, s2), then a prev flop; edge = s2 & ~prev.
  - A button rising before edge k is captured at k; the resulting action updates outputs at edge k+2.
  - One press gives exactly one action, however long it is held.
  - A button already high when reset releases produces one edge. This is accepted.
  - No debounce filtering in this block; upstream supplies clean levels.
- State machine, two states, RUN and SET:
  - RUN -> SET on mode edge. SET -> RUN on mode edge.
  - set_mode = (state==SET), updated on the same edge as the transition.
- RUN:
  - day_tick=1: day_idx increments modulo 7 (6->0).
  - week_wrap=1 for exactly the one cycle following a 6->0 advance; 0 otherwise.
  - Up/down edges are ignored.
  - blink=1 constantly.
- SET:
  - Up edge alone: day_idx+1 mod 7 (6->0).
  - Down edge alone: day_idx-1 mod 7 (0->6).
  - Up and down edges in the same cycle: no change.
  - day_tick is ignored and not queued: a midnight occurring during SET is lost by design.
  - week_wrap never asserts in SET.
- Simultaneous events:
  - Mode edge in the same cycle as up/down: only the mode transition happens; up/down is discarded.
  - Mode edge in the same cycle as day_tick while in RUN: both take effect. The day advances and the state enters SET on the same edge.
- Blink:
  - Entering SET loads counter=0 and blink=1.
  - In SET the counter counts 0..BLINK_DIV-1. When it reaches BLINK_DIV-1 it wraps to 0 and blink toggles.
  - The counter width is enough to hold BLINK_DIV-1.
  - Any up/down edge in SET restarts the counter at 0 and forces blink=1, so the new day is visible immediately.
  - Leaving SET forces blink=1 and holds the counter at 0.
- Invariant: day_idx never takes the value 7; the downstream decoders have no defined output for it.

Test Plan:
- Reset with DAY_RESET=0, then 7 day_tick pulses spaced 5 cycles apart:
  - day_idx steps 1,2,3,4,5,6,0.
  - week_wrap pulses once, for one cycle, after the 7th tick.
  - set_mode=0 and blink=1 throughout.
- Press btn_mode; in SET press btn_down once from day 0, then btn_up twice:
  - day_idx goes 6, then 0, then 1, each update 3 edges after the button rise.
  - set_mode=1; week_wrap stays 0.
- BLINK_DIV=4, in SET with no presses:
  - blink toggles every 4 cycles: 1111 0000 1111.
  - A btn_up press mid-low-phase forces blink=1 and restarts the 4-cycle count.
- In SET, day_tick pulses arrive: day_idx unchanged. In SET, btn_up and btn_down rise on the same cycle: day_idx unchanged.
- Hold btn_up high 100 cycles in SET: exactly one increment. Press btn_mode and btn_up simultaneously in SET: state returns to RUN, day_idx unchanged.
- Assert rst for 1 cycle while in SET with day_idx=4: next cycle day_idx=0, set_mode=0, blink=1, week_wrap=0.
